ising_cell_axi_ctrl: RTL and testbench
======================================

# ising_cell_axi_ctrl

AXI4-Lite slave that drives the per-cell synchronous write interface (`wready`, `wr_addr_match`, `wdata`) of the Ising cell array and returns each cell's `rdata` to the host. It also owns `ising_rstn`, the array-wide run gate. Start spins are loaded while `ising_rstn` is low; the array runs while it is high. The block sits between the host AXI interconnect and the cell array, one instance per array.

## Interface
Parameters:
- `NUM_CELLS`, 8 — number of cells addressed; 1..256.

Ports:
- `clk`  in  1  — single clock for AXI and cell write interface.
- `axi_rstn`  in  1  — asynchronous, active-low reset.
- `s_awaddr` in 32, `s_awvalid` in 1, `s_awready` out 1 — write address channel.
- `s_wdata` in 32, `s_wvalid` in 1, `s_wready` out 1 — write data channel; strobes ignored.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1 — write response channel.
- `s_araddr` in 32, `s_arvalid` in 1, `s_arready` out 1 — read address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1 — read data channel.
- `cell_wready`  out  1  — one-cycle write strobe broadcast to all cells.
- `cell_wr_addr_match`  out  NUM_CELLS  — one-hot cell select, valid with `cell_wready`.
- `cell_wdata`  out  32  — write data broadcast to all cells.
- `cell_rdata`  in  32*NUM_CELLS  — cell i's `rdata` at bits [32i+31:32i].
- `ising_rstn`  out  1  — array run gate; 0 means hold/load spins, 1 means run.

## Operation
- Address map, byte addresses, `addr[1:0]` ignored:
  - 0x000 CTRL: bit0 START.
  - 0x004 RUN_CYCLES: 32-bit register, reset 0.
  - 0x008 STATUS: bit0 BUSY, bit1 DONE.
  - 0x100 + 4*i: cell i, for i < NUM_CELLS.
  - All other addresses are unmapped.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, `s_awready` and `s_wready` are each high until their own handshake. The address and data are captured independently, in either order or in the same cycle.
  - When both are captured, the write executes in that cycle and the FSM moves to W_RESP with `s_bvalid`=1.
  - The FSM holds W_RESP until `s_bready`, then returns to W_IDLE with both readies high again.
- Cell write:
  - `cell_wready`=1 for exactly one cycle, the cycle after the write executes.
  - In that cycle, `cell_wr_addr_match` has only bit i set and `cell_wdata`=`s_wdata`.
  - Response is OKAY (2'b00).
- Cell write while BUSY: no strobe is issued and the response is SLVERR (2'b10).
- Unmapped write: no side effect; response SLVERR.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, `s_arready`=1.
  - On the AR handshake, the data is selected and registered, the FSM moves to R_DATA with `s_rvalid`=1, and `s_arready`=0.
  - `s_rdata`/`s_rresp` are held stable until `s_rready`, then the FSM returns to R_IDLE.
- Read data sources:
  - Cell read: `cell_rdata[32i+31:32i]` as sampled at the AR handshake.
  - STATUS read: {30'b0, DONE, BUSY}.
  - CTRL read: 0.
  - Unmapped read: 0 with SLVERR.
- The read and write paths are fully independent and may complete in the same cycle.
- Reset values: all `s_*ready` = 1; `s_bvalid`, `s_rvalid`, `s_rdata`, `s_bresp`, `s_rresp` = 0; `cell_wready`, `cell_wr_addr_match`, `cell_wdata` = 0; `ising_rstn` = 0; BUSY = DONE = 0.

## Timing
- Write, AW and W in the same cycle (T): `s_bvalid` rises at T+1 and `cell_wready` is high at T+1 only.
- Read latency: `s_rvalid` rises one cycle after the AR handshake. Maximum throughput is one read per 2 cycles and one write per 2 cycles.
- A read of cell i in the same cycle as the write handshake to cell i returns the old value.
- Asynchronous reset mid-transaction:
  - Outputs go to their reset values immediately.
  - Pending AW/W captures are discarded.
  - `ising_rstn` drops to 0, freezing the array.
- The run timer follows Configuration.

## Configuration
- `ISING_RUN_TIMER_EN` defined:
  - A write of START=1 while idle loads the counter from RUN_CYCLES, sets BUSY, and clears DONE.
  - `ising_rstn`=1 for exactly RUN_CYCLES cycles, starting the cycle after the write executes. The counter decrements each cycle.
  - At terminal count, `ising_rstn`=0 and BUSY=0 in the same cycle, and DONE=1 (sticky until the next START).
  - RUN_CYCLES=0: `ising_rstn` stays 0, and DONE=1 the cycle after the write.
  - START while BUSY is ignored with response OKAY.
  - START=0 writes have no effect.
- `ISING_RUN_TIMER_EN` undefined:
  - CTRL bit0 is a plain register driving `ising_rstn` directly (reset 0). CTRL reads return it.
  - BUSY = `ising_rstn`; DONE always 0.
  - RUN_CYCLES reads 0 and writes are OKAY with no effect.
  - No counter logic is present.

## Test plan
- Reset, then write 0x1 to 0x10C (cell 3) with AW and W together → `cell_wready` high for 1 cycle, `cell_wr_addr_match`=8'b0000_1000, `cell_wdata`=0x1, `s_bresp`=00.
- W presented 3 cycles before AW to 0x100 → exactly one strobe, issued after the AW handshake; `s_bready` held low 4 cycles → `s_bvalid` held and no new write is accepted.
- Read 0x104 with cell 1 driving 0x1 → `s_rvalid` one cycle later, `s_rdata`=0x1, `s_rresp`=00; read 0x400 → `s_rdata`=0, `s_rresp`=10.
- Timer on: RUN_CYCLES=5, START=1 → `ising_rstn` high exactly 5 cycles, STATUS goes 0x1 then 0x2; a cell write during the run → SLVERR, no strobe.
- Timer on: RUN_CYCLES=0, START → `ising_rstn` never rises, STATUS=0x2. Timer off: CTRL=1 → `ising_rstn`=1 and STATUS=0x1.
- Assert `axi_rstn` low mid-run and mid-read → `ising_rstn`, `s_rvalid`, `s_bvalid` = 0 immediately; after release the next transaction completes normally.

Source files
------------

// File: rtl/ising_cell_axi_ctrl.sv
// AXI4-Lite slave fronting an Ising cell array: broadcasts one-hot cell writes,
// returns per-cell rdata, and owns the array-wide run gate (ising_rstn).
// Optional feature macro: ISING_RUN_TIMER_EN (hardware run-cycle timer behind CTRL.START).
module ising_cell_axi_ctrl #(
  parameter int unsigned NUM_CELLS = 8
) (
  input  logic                      clk,
  input  logic                      axi_rstn,
  input  logic [31:0]               s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [31:0]               s_wdata,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [31:0]               s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [31:0]               s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      cell_wready,
  output logic [NUM_CELLS-1:0]      cell_wr_addr_match,
  output logic [31:0]               cell_wdata,
  input  logic [32*NUM_CELLS-1:0]   cell_rdata,
  output logic                      ising_rstn
);

  localparam int unsigned IdxW     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [29:0] CellBase = 30'd64;  // byte 0x100
  localparam logic [29:0] CellEnd  = CellBase + 30'(NUM_CELLS);

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic            aw_done_q, w_done_q;
  logic [29:0]     awaddr_q;
  logic [31:0]     wdata_q;
  logic            aw_hs, w_hs, ar_hs, wr_exec;
  logic [29:0]     wr_word, rd_word;
  logic [31:0]     wr_data;
  logic            wr_is_ctrl, wr_is_run, wr_is_stat, wr_is_cell, wr_cell_ok;
  logic [1:0]      wr_resp;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic [NUM_CELLS-1:0] wr_onehot;
  logic            busy, done;
  logic [31:0]     ctrl_rd, run_rd;
  logic            rd_is_cell;
  logic [31:0]     rd_data, cell_sel;
  logic [1:0]      rd_resp;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  // ---------------- write path ----------------
  assign s_awready = (w_state_q == WIdle) && !aw_done_q;
  assign s_wready  = (w_state_q == WIdle) && !w_done_q;
  assign s_bvalid  = (w_state_q == WResp);
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign wr_exec   = (w_state_q == WIdle) && (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // Decode the effective write address/data (captured or live) and the response.
  always_comb begin
    wr_word    = aw_done_q ? awaddr_q : s_awaddr[31:2];
    wr_data    = w_done_q ? wdata_q : s_wdata;
    wr_is_ctrl = (wr_word == 30'd0);
    wr_is_run  = (wr_word == 30'd1);
    wr_is_stat = (wr_word == 30'd2);
    wr_is_cell = (wr_word >= CellBase) && (wr_word < CellEnd);
    wr_idx     = IdxW'(wr_word - CellBase);
    wr_cell_ok = wr_is_cell && !busy;
    wr_resp    = (wr_is_ctrl || wr_is_run || wr_is_stat || wr_cell_ok) ? 2'b00 : 2'b10;
    wr_onehot    = '0;
    wr_onehot[0] = 1'b1;
    wr_onehot    = wr_onehot << wr_idx;
  end

  // Write FSM next state.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      WIdle:   if (wr_exec) w_state_d = WResp;
      WResp:   if (s_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write FSM state, independent AW/W capture, and response code.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      w_state_q <= WIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      s_bresp   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      if (wr_exec) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        s_bresp   <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_done_q <= 1'b1;
          awaddr_q  <= s_awaddr[31:2];
        end
        if (w_hs) begin
          w_done_q <= 1'b1;
          wdata_q  <= s_wdata;
        end
      end
    end
  end

  // One-cycle cell write strobe, issued the cycle after the write executes.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cell_wready        <= 1'b0;
      cell_wr_addr_match <= '0;
      cell_wdata         <= '0;
    end else begin
      cell_wready        <= wr_exec && wr_cell_ok;
      cell_wr_addr_match <= (wr_exec && wr_cell_ok) ? wr_onehot : '0;
      if (wr_exec && wr_cell_ok) cell_wdata <= wr_data;
    end
  end

`ifdef ISING_RUN_TIMER_EN
  logic [31:0] run_cycles_q, cnt_q;
  logic        busy_q, done_q, run_q;

  // Run timer: START loads the counter and holds the gate high for RUN_CYCLES cycles.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      run_cycles_q <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      if (wr_exec && wr_is_run) run_cycles_q <= wr_data;
      if (wr_exec && wr_is_ctrl && wr_data[0] && !busy_q) begin
        if (run_cycles_q == '0) begin
          done_q <= 1'b1;
        end else begin
          cnt_q  <= run_cycles_q;
          busy_q <= 1'b1;
          run_q  <= 1'b1;
          done_q <= 1'b0;
        end
      end else if (busy_q) begin
        cnt_q <= cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          busy_q <= 1'b0;
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ising_rstn = run_q;
  assign ctrl_rd    = '0;
  assign run_rd     = run_cycles_q;
`else
  logic ctrl_q;

  // CTRL bit0 drives the run gate directly.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) ctrl_q <= 1'b0;
    else if (wr_exec && wr_is_ctrl) ctrl_q <= wr_data[0];
  end

  assign busy       = ctrl_q;
  assign done       = 1'b0;
  assign ising_rstn = ctrl_q;
  assign ctrl_rd    = {31'b0, ctrl_q};
  assign run_rd     = '0;
`endif

  // ---------------- read path ----------------
  assign s_arready = (r_state_q == RIdle);
  assign s_rvalid  = (r_state_q == RData);
  assign ar_hs     = s_arvalid && s_arready;

  // Read address decode and data select.
  always_comb begin
    rd_word    = s_araddr[31:2];
    rd_is_cell = (rd_word >= CellBase) && (rd_word < CellEnd);
    rd_idx     = IdxW'(rd_word - CellBase);
    cell_sel   = '0;
    for (int i = 0; i < int'(NUM_CELLS); i++) begin
      if (rd_idx == IdxW'(i)) cell_sel = cell_rdata[32*i +: 32];
    end
    rd_data = '0;
    rd_resp = 2'b00;
    if (rd_word == 30'd0)      rd_data = ctrl_rd;
    else if (rd_word == 30'd1) rd_data = run_rd;
    else if (rd_word == 30'd2) rd_data = {30'b0, done, busy};
    else if (rd_is_cell)       rd_data = cell_sel;
    else                       rd_resp = 2'b10;
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      RIdle:   if (s_arvalid) r_state_d = RData;
      RData:   if (s_rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read FSM state and registered read data, held until accepted.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state_q <= RIdle;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        s_rdata <= rd_data;
        s_rresp <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_ising_cell_axi_ctrl.sv
// Directed self-checking bench for ising_cell_axi_ctrl; follows ISING_RUN_TIMER_EN.
module tb_ising_cell_axi_ctrl;
  localparam int NC = 8;

  logic clk = 1'b0;
  logic axi_rstn;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, cell_wdata;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0] s_bresp, s_rresp;
  logic cell_wready, ising_rstn;
  logic [NC-1:0] cell_wr_addr_match;
  logic [32*NC-1:0] cell_rdata;

  typedef struct {logic [31:0] d; logic [1:0] r;} rexp_t;
  logic [1:0] bq[$];
  rexp_t      rq[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ising_cell_axi_ctrl #(.NUM_CELLS(NC)) dut (
    .clk(clk), .axi_rstn(axi_rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cell_wready(cell_wready), .cell_wr_addr_match(cell_wr_addr_match),
    .cell_wdata(cell_wdata), .cell_rdata(cell_rdata), .ising_rstn(ising_rstn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_b(input string tag);
    logic [1:0] e;
    if (bq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed bvalid with no expected response queued", tag);
    end else begin
      e = bq.pop_front();
      chk(tag, 32'(s_bresp), 32'(e));
    end
  endtask

  // AW and W together; checks strobe timing/content and response.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input bit strobe, input int idx);
    @(negedge clk);
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wvalid = 1'b1; s_bready = 1'b1;
    bq.push_back(resp);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_bvalid", 32'(s_bvalid), 32'd1);
    chk("wr_strobe", 32'(cell_wready), 32'(strobe));
    if (strobe) begin
      chk("wr_match", 32'(cell_wr_addr_match), 32'(1) << idx);
      chk("wr_wdata", cell_wdata, d);
    end else begin
      chk("wr_match_idle", 32'(cell_wr_addr_match), 32'd0);
    end
    pop_b("wr_bresp");
    @(negedge clk);
    chk("wr_strobe_once", 32'(cell_wready), 32'd0);
    chk("wr_bvalid_done", 32'(s_bvalid), 32'd0);
  endtask

  // Read with one cycle of rready backpressure.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    rexp_t e;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
    rq.push_back('{d, resp});
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("rd_rvalid", 32'(s_rvalid), 32'd1);
    chk("rd_arready_low", 32'(s_arready), 32'd0);
    e = rq.pop_front();
    chk("rd_data", s_rdata, e.d);
    chk("rd_resp", 32'(s_rresp), 32'(e.r));
    @(negedge clk);
    chk("rd_hold_valid", 32'(s_rvalid), 32'd1);
    chk("rd_hold_data", s_rdata, e.d);
    s_rready = 1'b1;
    @(negedge clk);
    chk("rd_rvalid_done", 32'(s_rvalid), 32'd0);
    chk("rd_arready_back", 32'(s_arready), 32'd1);
    s_rready = 1'b0;
  endtask

`ifdef ISING_RUN_TIMER_EN
  // Issue START and count cycles with the run gate high over a fixed window.
  task automatic run_start(output int n);
    @(negedge clk);
    s_awaddr = 32'h0; s_awvalid = 1'b1; s_wdata = 32'h1; s_wvalid = 1'b1; s_bready = 1'b1;
    bq.push_back(2'b00);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        pop_b("start_bresp");
      end
      if (ising_rstn) n++;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    axi_rstn = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    cell_rdata = '0;
    cell_rdata[63:32]   = 32'h1;
    cell_rdata[127:96]  = 32'hDEAD_BEEF;
    cell_rdata[255:224] = 32'h7777_0007;
    #12;
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_wready", 32'(s_wready), 32'd1);
    chk("rst_arready", 32'(s_arready), 32'd1);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
    chk("rst_cell_wready", 32'(cell_wready), 32'd0);
    chk("rst_match", 32'(cell_wr_addr_match), 32'd0);
    chk("rst_cell_wdata", cell_wdata, 32'd0);
    chk("rst_ising_rstn", 32'(ising_rstn), 32'd0);
    @(negedge clk);
    axi_rstn = 1'b1;

    // Basic cell write and boundaries.
    do_write(32'h10C, 32'h1, 2'b00, 1'b1, 3);
    do_write(32'h11C, 32'hA5A5_0000, 2'b00, 1'b1, 7);
    do_write(32'h120, 32'h5, 2'b10, 1'b0, 0);
    do_write(32'h200, 32'h5, 2'b10, 1'b0, 0);

    // W three cycles ahead of AW, then held response.
    @(negedge clk);
    s_wdata = 32'h77; s_wvalid = 1'b1; s_bready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_wvalid = 1'b0;
      chk("early_w_wready", 32'(s_wready), 32'd0);
      chk("early_w_nostrobe", 32'(cell_wready), 32'd0);
      chk("early_w_nobvalid", 32'(s_bvalid), 32'd0);
    end
    s_awaddr = 32'h100; s_awvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("late_aw_bvalid", 32'(s_bvalid), 32'd1);
    chk("late_aw_strobe", 32'(cell_wready), 32'd1);
    chk("late_aw_match", 32'(cell_wr_addr_match), 32'd1);
    chk("late_aw_wdata", cell_wdata, 32'h77);
    pop_b("late_aw_bresp");
    s_awaddr = 32'h104; s_awvalid = 1'b1; s_wdata = 32'h99; s_wvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bhold_bvalid", 32'(s_bvalid), 32'd1);
      chk("bhold_nostrobe", 32'(cell_wready), 32'd0);
      chk("bhold_awready", 32'(s_awready), 32'd0);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    chk("bhold_released", 32'(s_bvalid), 32'd0);
    chk("bhold_awready_back", 32'(s_awready), 32'd1);

    // Reads.
    do_read(32'h104, 32'h1, 2'b00);
    do_read(32'h400, 32'h0, 2'b10);
    do_read(32'h10E, 32'hDEAD_BEEF, 2'b00);
    do_read(32'h11C, 32'h7777_0007, 2'b00);
    do_read(32'h120, 32'h0, 2'b10);
    do_read(32'h008, 32'h0, 2'b00);

`ifdef ISING_RUN_TIMER_EN
    do_write(32'h004, 32'd5, 2'b00, 1'b0, 0);
    do_read(32'h004, 32'd5, 2'b00);
    run_start(n);
    chk("run5_len", 32'(n), 32'd5);
    do_read(32'h008, 32'h2, 2'b00);
    do_write(32'h004, 32'd30, 2'b00, 1'b0, 0);
    do_write(32'h000, 32'h1, 2'b00, 1'b0, 0);
    do_read(32'h008, 32'h1, 2'b00);
    do_write(32'h108, 32'h7, 2'b10, 1'b0, 0);
    do_write(32'h000, 32'h1, 2'b00, 1'b0, 0);
    for (int c = 0; c < 100; c++) begin
      if (!ising_rstn) break;
      @(negedge clk);
    end
    chk("run30_ended", 32'(ising_rstn), 32'd0);
    do_read(32'h008, 32'h2, 2'b00);
    do_write(32'h004, 32'd0, 2'b00, 1'b0, 0);
    run_start(n);
    chk("run0_len", 32'(n), 32'd0);
    do_read(32'h008, 32'h2, 2'b00);
    do_read(32'h000, 32'h0, 2'b00);
    do_write(32'h004, 32'd50, 2'b00, 1'b0, 0);
    do_write(32'h000, 32'h1, 2'b00, 1'b0, 0);
`else
    do_write(32'h000, 32'h1, 2'b00, 1'b0, 0);
    chk("ctrl_gate_on", 32'(ising_rstn), 32'd1);
    do_read(32'h008, 32'h1, 2'b00);
    do_read(32'h000, 32'h1, 2'b00);
    do_write(32'h108, 32'h7, 2'b10, 1'b0, 0);
    do_write(32'h004, 32'h9, 2'b00, 1'b0, 0);
    do_read(32'h004, 32'h0, 2'b00);
    do_write(32'h000, 32'h0, 2'b00, 1'b0, 0);
    chk("ctrl_gate_off", 32'(ising_rstn), 32'd0);
    do_read(32'h008, 32'h0, 2'b00);
    do_write(32'h000, 32'h1, 2'b00, 1'b0, 0);
`endif

    // Asynchronous reset mid-run, mid-read, with a pending W capture.
    chk("pre_rst_gate", 32'(ising_rstn), 32'd1);
    @(negedge clk);
    s_araddr = 32'h104; s_arvalid = 1'b1; s_rready = 1'b0;
    s_wdata = 32'hAA; s_wvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0; s_wvalid = 1'b0;
    chk("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
    axi_rstn = 1'b0;
    #1;
    chk("rst_mid_gate", 32'(ising_rstn), 32'd0);
    chk("rst_mid_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_mid_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_mid_wready", 32'(s_wready), 32'd1);
    chk("rst_mid_arready", 32'(s_arready), 32'd1);
    @(negedge clk);
    axi_rstn = 1'b1;
    s_awaddr = 32'h104; s_awvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("rst_w_discarded", 32'(s_bvalid), 32'd0);
    s_wdata = 32'h55; s_wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    s_wvalid = 1'b0;
    chk("post_rst_bvalid", 32'(s_bvalid), 32'd1);
    chk("post_rst_strobe", 32'(cell_wready), 32'd1);
    chk("post_rst_match", 32'(cell_wr_addr_match), 32'd2);
    chk("post_rst_wdata", cell_wdata, 32'h55);
    pop_b("post_rst_bresp");
    do_read(32'h104, 32'h1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
